// File: rtl/gcd_check_pkg.sv
// Shared types and default sizing for the GCD response checker.
package gcd_check_pkg;

  localparam int unsigned DefW       = 2;
  localparam int unsigned DefDepth   = 16;
  localparam int unsigned DefTimeout = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } check_state_t;

endpackage

// File: rtl/gcd_exp_ram.sv
// Expected-result table: registered write port, asynchronous read port.
module gcd_exp_ram #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  // Table storage; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/gcd_result_checker.sv
// Compares each new GCD result against a preloaded table and reports counts,
// first failure, timeout and pass/fail.
module gcd_result_checker
  import gcd_check_pkg::*;
#(
  parameter int unsigned W       = DefW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned TIMEOUT = DefTimeout,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          exp_wr_en,
  input  logic [AW-1:0] exp_wr_addr,
  input  logic [W-1:0]  exp_wr_data,
  input  logic [AW:0]   exp_count,
  input  logic          start,
  input  logic [W-1:0]  io_outputGCD,
  input  logic          io_outputValid,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [AW:0]   match_count,
  output logic [AW:0]   mismatch_count,
  output logic [AW-1:0] first_err_idx,
  output logic [W-1:0]  first_err_got
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  check_state_t  r_state;
  logic          r_valid_q;
  logic [AW:0]   r_n;
  logic [AW-1:0] r_idx;
  logic [TW-1:0] r_timer;
  logic          r_done;
  logic          r_pass;
  logic          r_timeout;
  logic [AW:0]   r_match;
  logic [AW:0]   r_mismatch;
  logic [AW-1:0] r_err_idx;
  logic [W-1:0]  r_err_got;

  logic [W-1:0]  w_exp;
  logic          w_event;
  logic          w_hit;
  logic          w_last;
  logic          w_expire;
  logic          w_start_ok;
  logic          w_wr_en;
  logic [AW:0]   w_n_start;

  // Table is frozen while a run is in progress.
  assign w_wr_en    = exp_wr_en & (r_state != CHECK);
  assign w_start_ok = start & (r_state != CHECK);
  assign w_n_start  = (exp_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : exp_count;

  // Only a rising edge of the level-valid counts as a new result.
  assign w_event  = (r_state == CHECK) & io_outputValid & ~r_valid_q;
  assign w_hit    = (io_outputGCD == w_exp);
  assign w_last   = ({1'b0, r_idx} == (r_n - 1'b1));
  assign w_expire = (r_timer == TW'(TIMEOUT - 1));

  gcd_exp_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_exp_ram (
    .clock     (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (exp_wr_addr),
    .i_wr_data (exp_wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_exp)
  );

  // Run FSM, edge detect, counters, timer and first-error capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_valid_q  <= 1'b0;
      r_n        <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_match    <= '0;
      r_mismatch <= '0;
      r_err_idx  <= '0;
      r_err_got  <= '0;
    end else begin
      r_valid_q <= io_outputValid;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_n        <= w_n_start;
            r_idx      <= '0;
            r_timer    <= '0;
            r_match    <= '0;
            r_mismatch <= '0;
            r_err_idx  <= '0;
            r_err_got  <= '0;
            r_timeout  <= 1'b0;
            if (w_n_start == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= CHECK;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (w_event) begin
            r_timer <= '0;
            r_idx   <= r_idx + 1'b1;
            if (w_hit) begin
              r_match <= r_match + 1'b1;
            end else begin
              r_mismatch <= r_mismatch + 1'b1;
              if (r_mismatch == '0) begin
                r_err_idx <= r_idx;
                r_err_got <= io_outputGCD;
              end
            end
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_pass  <= w_hit & (r_mismatch == '0);
            end
          end else if (w_expire) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy           = (r_state == CHECK);
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign match_count    = r_match;
  assign mismatch_count = r_mismatch;
  assign first_err_idx  = r_err_idx;
  assign first_err_got  = r_err_got;

endmodule

// File: tb/tb_gcd_result_checker.sv
// Scenario bench for gcd_result_checker with a result scoreboard.
module tb_gcd_result_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       exp_wr_en;
  logic [3:0] exp_wr_addr;
  logic [1:0] exp_wr_data;
  logic [4:0] exp_count;
  logic       start;
  logic [1:0] io_outputGCD;
  logic       io_outputValid;
  logic       busy, done, pass, timeout;
  logic [4:0] match_count, mismatch_count;
  logic [3:0] first_err_idx;
  logic [1:0] first_err_got;

  always #5 clock = ~clock;

  gcd_result_checker u_dut (
    .clock          (clock),
    .reset          (reset),
    .exp_wr_en      (exp_wr_en),
    .exp_wr_addr    (exp_wr_addr),
    .exp_wr_data    (exp_wr_data),
    .exp_count      (exp_count),
    .start          (start),
    .io_outputGCD   (io_outputGCD),
    .io_outputValid (io_outputValid),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .first_err_idx  (first_err_idx),
    .first_err_got  (first_err_got)
  );

  typedef struct {
    int match;
    int mis;
    int eidx;
    int egot;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] tb_tab [16];
  int         m_match, m_mis, m_idx, m_eidx, m_egot;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Writes one entry; 'accepted' says whether the model table should follow.
  task automatic write_entry(input int a, input logic [1:0] d, input bit accepted);
    @(negedge clock);
    exp_wr_en   = 1'b1;
    exp_wr_addr = 4'(a);
    exp_wr_data = d;
    @(posedge clock);
    #1 exp_wr_en = 1'b0;
    if (accepted) tb_tab[a] = d;
  endtask

  task automatic start_run(input int cnt);
    @(negedge clock);
    start     = 1'b1;
    exp_count = 5'(cnt);
    m_match = 0; m_mis = 0; m_idx = 0; m_eidx = 0; m_egot = 0;
    @(negedge clock);
    start = 1'b0;
  endtask

  // One-cycle valid pulse; expected counters pushed, then popped and compared.
  task automatic pulse(input logic [1:0] v);
    exp_t e;
    @(negedge clock);
    io_outputValid = 1'b1;
    io_outputGCD   = v;
    if (v == tb_tab[m_idx]) m_match++;
    else begin
      if (m_mis == 0) begin m_eidx = m_idx; m_egot = int'(v); end
      m_mis++;
    end
    m_idx++;
    sb.push_back('{m_match, m_mis, m_eidx, m_egot});
    @(negedge clock);
    io_outputValid = 1'b0;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: no expected entry queued");
    end else begin
      e = sb.pop_front();
      if (match_count !== 5'(e.match)) begin
        n_bad++;
        $display("FAIL match_count: got %0d want %0d", match_count, e.match);
      end
      n_cmp++;
      if (mismatch_count !== 5'(e.mis)) begin
        n_bad++;
        $display("FAIL mismatch_count: got %0d want %0d", mismatch_count, e.mis);
      end
      n_cmp++;
      if ({first_err_idx, first_err_got} !== {4'(e.eidx), 2'(e.egot)}) begin
        n_bad++;
        $display("FAIL first_err: got idx %0d val %0d want idx %0d val %0d",
                 first_err_idx, first_err_got, e.eidx, e.egot);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({busy, done, pass, timeout, match_count, mismatch_count, first_err_idx,
         first_err_got} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got b%0b d%0b p%0b t%0b m%0d x%0d want all 0",
               busy, done, pass, timeout, match_count, mismatch_count);
    end
  endtask

  task automatic load_1213();
    write_entry(0, 2'd1, 1'b1);
    write_entry(1, 2'd2, 1'b1);
    write_entry(2, 2'd1, 1'b1);
    write_entry(3, 2'd3, 1'b1);
  endtask

  task automatic test_all_match();
    load_1213();
    start_run(4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: got %0b want 1", busy);
    end
    pulse(2'd1); pulse(2'd2); pulse(2'd1); pulse(2'd3);
    n_cmp++;
    if ({done, pass, busy, timeout} !== 4'b1100) begin
      n_bad++;
      $display("FAIL all_match_end: got d%0b p%0b b%0b t%0b want d1 p1 b0 t0",
               done, pass, busy, timeout);
    end
  endtask

  task automatic test_mismatch();
    start_run(4);
    pulse(2'd1); pulse(2'd2); pulse(2'd2); pulse(2'd3);
    n_cmp++;
    if ({done, pass, timeout} !== 3'b100) begin
      n_bad++;
      $display("FAIL mismatch_end: got d%0b p%0b t%0b want d1 p0 t0", done, pass, timeout);
    end
  endtask

  task automatic test_held_valid();
    write_entry(0, 2'd1, 1'b1);
    write_entry(1, 2'd1, 1'b1);
    @(negedge clock);
    io_outputValid = 1'b1;
    io_outputGCD   = 2'd1;
    start_run(2);
    repeat (10) @(negedge clock);
    n_cmp++;
    if ({match_count, mismatch_count, busy} !== {5'd0, 5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL held_valid: got m%0d x%0d b%0b want m0 x0 b1",
               match_count, mismatch_count, busy);
    end
    io_outputValid = 1'b0;
    pulse(2'd1); pulse(2'd1);
    n_cmp++;
    if ({done, pass} !== 2'b11) begin
      n_bad++;
      $display("FAIL held_valid_end: got d%0b p%0b want d1 p1", done, pass);
    end
  endtask

  task automatic test_timeout();
    int edges;
    write_entry(0, 2'd1, 1'b1);
    write_entry(1, 2'd2, 1'b1);
    write_entry(2, 2'd1, 1'b1);
    start_run(3);
    pulse(2'd1);
    edges = 0;
    while (!done && edges < 200) begin
      @(negedge clock);
      edges++;
    end
    n_cmp++;
    if (edges !== 64) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles want 64", edges);
    end
    n_cmp++;
    if ({done, timeout, pass, busy, match_count} !== {4'b1100, 5'd1}) begin
      n_bad++;
      $display("FAIL timeout_flags: got d%0b t%0b p%0b b%0b m%0d want d1 t1 p0 b0 m1",
               done, timeout, pass, busy, match_count);
    end
  endtask

  task automatic test_zero_count();
    start_run(0);
    n_cmp++;
    if ({done, pass, busy, timeout} !== 4'b1100) begin
      n_bad++;
      $display("FAIL zero_count: got d%0b p%0b b%0b t%0b want d1 p1 b0 t0",
               done, pass, busy, timeout);
    end
  endtask

  task automatic test_reset_mid_run();
    load_1213();
    start_run(4);
    pulse(2'd1); pulse(2'd2);
    write_entry(2, 2'd3, 1'b0);
    test_reset();
    start_run(4);
    pulse(2'd1); pulse(2'd2); pulse(2'd1); pulse(2'd3);
    n_cmp++;
    if ({done, pass} !== 2'b11) begin
      n_bad++;
      $display("FAIL write_in_check: got d%0b p%0b want d1 p1", done, pass);
    end
  endtask

  initial begin
    reset          = 1'b1;
    exp_wr_en      = 1'b0;
    exp_wr_addr    = '0;
    exp_wr_data    = '0;
    exp_count      = '0;
    start          = 1'b0;
    io_outputGCD   = '0;
    io_outputValid = 1'b0;
    for (int i = 0; i < 16; i++) tb_tab[i] = '0;
    test_reset();
    test_all_match();
    test_mismatch();
    test_held_valid();
    test_timeout();
    test_zero_count();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
